// File: rtl/uart_alu_packet_parser.sv
// uart_alu_packet_parser: splits the uart_rx byte stream into command packets.
// Header: opcode, reserved byte, 16-bit little-endian total length (includes the 4 header bytes).
// Arithmetic opcodes (0x01..0x0F) become little-endian operand words on a valid/ready port;
// opcode 0xEC echoes its payload to the tx path; anything else is drained and flagged on err_o.
// Optional inter-byte timeout: define UART_ALU_PARSER_TIMEOUT_EN.
module uart_alu_packet_parser #(
  parameter int unsigned OPERAND_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [7:0]               s_axis_tdata_i,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  output logic [7:0]               m_opcode_o,
  output logic [OPERAND_WIDTH-1:0] m_operand_o,
  output logic                     m_valid_o,
  output logic                     m_last_o,
  input  logic                     m_ready_i,
  output logic [7:0]               echo_tdata_o,
  output logic                     echo_tvalid_o,
  output logic                     echo_tlast_o,
  input  logic                     echo_tready_i,
  output logic                     err_o
);

  localparam int unsigned BYTES   = OPERAND_WIDTH / 8;
  localparam int unsigned KW      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [7:0]  OP_ECHO = 8'hEC;

  typedef enum logic [2:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_EMIT, S_ECHO, S_DRAIN
  } state_t;

  // Reject parameter sets the byte packing cannot represent.
  if ((OPERAND_WIDTH == 0) || ((OPERAND_WIDTH % 8) != 0) || (TIMEOUT_CYCLES == 0)) begin : g_bad_cfg
    $error("uart_alu_packet_parser: OPERAND_WIDTH must be a nonzero multiple of 8, TIMEOUT_CYCLES nonzero");
  end

  state_t                   r_state;
  state_t                   w_next;
  logic [7:0]               r_opcode;
  logic [7:0]               r_len_lo;
  logic [15:0]              r_remaining;
  logic [OPERAND_WIDTH-1:0] r_operand;
  logic [KW-1:0]            r_k;
  logic                     r_valid;
  logic                     r_last;
  logic                     r_err;
  logic [15:0]              w_len;
  logic [15:0]              w_rem_load;
  logic                     w_tready;
  logic                     w_accept;
  logic                     w_err;
  logic                     w_timeout;
  logic                     w_word_done;
  logic                     w_rem_one;
  logic                     w_arith_op;
  logic                     w_len_ok;

  assign w_len       = {s_axis_tdata_i, r_len_lo};
  assign w_rem_load  = w_len - 16'd4;
  assign w_word_done = (r_k == KW'(BYTES - 1));
  assign w_rem_one   = (r_remaining == 16'd1);
  assign w_arith_op  = (r_opcode[7:4] == 4'd0) && (r_opcode[3:0] != 4'd0);
  assign w_len_ok    = (w_rem_load >= 16'(BYTES)) && ((w_rem_load % 16'(BYTES)) == 16'd0);
  assign w_accept    = s_axis_tvalid_i && w_tready;

  assign s_axis_tready_o = w_tready;
  assign m_opcode_o      = r_opcode;
  assign m_operand_o     = r_operand;
  assign m_valid_o       = r_valid;
  assign m_last_o        = r_last;
  assign err_o           = r_err;

`ifdef UART_ALU_PARSER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_idle_cnt;
  logic          w_tmo_state;

  assign w_tmo_state = (r_state != S_IDLE) && (r_state != S_EMIT);
  assign w_timeout   = w_tmo_state && !w_accept && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter between payload bytes; cleared by any accepted byte.
  always_ff @(posedge clk_i) begin
    if (reset_i || !w_tmo_state || w_accept || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Byte-side handshake and the combinational echo pass-through.
  always_comb begin
    w_tready      = 1'b0;
    echo_tdata_o  = 8'd0;
    echo_tvalid_o = 1'b0;
    echo_tlast_o  = 1'b0;
    if (!reset_i) begin
      case (r_state)
        S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN: w_tready = 1'b1;
        S_ECHO: begin
          w_tready      = echo_tready_i;
          echo_tdata_o  = s_axis_tdata_i;
          echo_tvalid_o = s_axis_tvalid_i;
          echo_tlast_o  = w_rem_one;
        end
        default: w_tready = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode, including header classification on the length high byte.
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_RSVD;
      S_RSVD:   if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: if (w_accept) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_len < 16'd4) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end else if (r_opcode == OP_ECHO) begin
            w_next = (w_rem_load == 16'd0) ? S_IDLE : S_ECHO;
          end else if (w_arith_op && w_len_ok) begin
            w_next = S_OPERAND;
          end else begin
            w_err  = 1'b1;
            w_next = (w_rem_load != 16'd0) ? S_DRAIN : S_IDLE;
          end
        end
      end
      S_OPERAND: if (w_accept && w_word_done) w_next = S_EMIT;
      S_EMIT:    if (m_ready_i) w_next = r_last ? S_IDLE : S_OPERAND;
      S_ECHO, S_DRAIN: if (w_accept && w_rem_one) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_err  = 1'b1;
      w_next = S_IDLE;
    end
  end

  // Header fields, payload counter, operand assembly and the ALU-side word register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_opcode    <= 8'd0;
      r_len_lo    <= 8'd0;
      r_remaining <= 16'd0;
      r_operand   <= '0;
      r_k         <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_err;
      case (r_state)
        S_IDLE:   if (w_accept) r_opcode <= s_axis_tdata_i;
        S_LEN_LO: if (w_accept) r_len_lo <= s_axis_tdata_i;
        S_LEN_HI: begin
          if (w_accept) begin
            r_remaining <= w_rem_load;
            r_k         <= '0;
          end
        end
        S_OPERAND: begin
          if (w_accept) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
              if (r_k == KW'(b)) r_operand[8*b +: 8] <= s_axis_tdata_i;
            end
            r_remaining <= r_remaining - 16'd1;
            if (w_word_done) begin
              r_k     <= '0;
              r_valid <= 1'b1;
              r_last  <= w_rem_one;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_EMIT: begin
          if (m_ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        S_ECHO, S_DRAIN: if (w_accept) r_remaining <= r_remaining - 16'd1;
        default: ;
      endcase
      if (w_timeout) begin
        r_operand <= '0;
        r_k       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_packet_parser.sv
// tb_uart_alu_packet_parser: directed and randomized packets against a packet-level reference model.
// With UART_ALU_PARSER_TIMEOUT_EN defined, also exercises the inter-byte timeout.
`timescale 1ns/1ps
module tb_uart_alu_packet_parser;

  logic        clk_i           = 1'b0;
  logic        reset_i         = 1'b1;
  logic [7:0]  s_axis_tdata_i  = 8'd0;
  logic        s_axis_tvalid_i = 1'b0;
  logic        s_axis_tready_o;
  logic [7:0]  m_opcode_o;
  logic [31:0] m_operand_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_i       = 1'b1;
  logic [7:0]  echo_tdata_o;
  logic        echo_tvalid_o;
  logic        echo_tlast_o;
  logic        echo_tready_i   = 1'b1;
  logic        err_o;

  uart_alu_packet_parser #(.OPERAND_WIDTH(32), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tready_o(s_axis_tready_o),
    .m_opcode_o(m_opcode_o), .m_operand_o(m_operand_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i),
    .echo_tdata_o(echo_tdata_o), .echo_tvalid_o(echo_tvalid_o), .echo_tlast_o(echo_tlast_o),
    .echo_tready_i(echo_tready_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  pkt_q[$];
  logic [40:0] exp_op[$];
  logic [40:0] obs_op[$];
  logic [8:0]  exp_echo[$];
  logic [8:0]  obs_echo[$];
  int          exp_err;
  int          err_seen = 0;
  int          err_acc = -1;
  int          acc_cnt = 0;
  int          hold_viol = 0;
  int          emit_rdy_viol = 0;
  int          err_long = 0;
  int          timeouts = 0;
  int          stall_cycles = 0;
  int          rdy_mode = 0;
  int          echo_mode = 0;
  bit          gaps = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_err = 1'b0;
  logic [40:0] prev_word = '0;

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Sink-side ready drivers.
  initial forever begin
    @(posedge clk_i);
    #1;
    m_ready_i     = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    echo_tready_i = (echo_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Observer: collects handshakes and protocol violations mid-cycle.
  initial forever begin
    @(negedge clk_i);
    if (reset_i) begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (err_o) begin
        err_seen++;
        err_acc = acc_cnt;
        if (prev_err) err_long++;
      end
      prev_err = err_o;
      if (prev_stall && (!m_valid_o || {m_last_o, m_opcode_o, m_operand_o} !== prev_word)) hold_viol++;
      prev_stall = m_valid_o && !m_ready_i;
      prev_word  = {m_last_o, m_opcode_o, m_operand_o};
      if (prev_stall) stall_cycles++;
      if (m_valid_o && s_axis_tready_o) emit_rdy_viol++;
      if (m_valid_o && m_ready_i) obs_op.push_back({m_last_o, m_opcode_o, m_operand_o});
      if (echo_tvalid_o && echo_tready_i) obs_echo.push_back({echo_tlast_o, echo_tdata_o});
      if (s_axis_tvalid_i && s_axis_tready_o) acc_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    int gap;
    s_axis_tdata_i  = b;
    s_axis_tvalid_i = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk_i);
      ok = s_axis_tready_o;
      @(posedge clk_i);
      #1;
    end
    s_axis_tvalid_i = 1'b0;
    if (!ok) timeouts++;
    gap = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_pkt();
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
  endtask

  task automatic make_packet(input logic [7:0] op, input int len);
    logic [15:0] l = 16'(len);
    pkt_q.delete();
    pkt_q.push_back(op);
    pkt_q.push_back(8'($urandom_range(0, 255)));
    pkt_q.push_back(l[7:0]);
    pkt_q.push_back(l[15:8]);
    for (int i = 4; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference model: what one whole packet must produce.
  task automatic model();
    logic [7:0] op = pkt_q[0];
    int len = int'({pkt_q[3], pkt_q[2]});
    int pay;
    exp_op.delete();
    exp_echo.delete();
    exp_err = 0;
    if (len < 4) begin
      exp_err = 1;
    end else begin
      pay = len - 4;
      if (op == 8'hEC) begin
        for (int i = 0; i < pay; i++) exp_echo.push_back({1'(i == pay - 1), pkt_q[4 + i]});
      end else if (op >= 8'd1 && op <= 8'd15 && pay >= 4 && pay % 4 == 0) begin
        for (int w = 0; w < pay / 4; w++)
          exp_op.push_back({1'(w == pay / 4 - 1), op,
                            pkt_q[4 + 4*w + 3], pkt_q[4 + 4*w + 2], pkt_q[4 + 4*w + 1], pkt_q[4 + 4*w]});
      end else begin
        exp_err = 1;
      end
    end
  endtask

  task automatic prep();
    model();
    obs_op.delete();
    obs_echo.delete();
    err_seen = 0;
    err_acc  = -1;
    acc_cnt  = 0;
  endtask

  task automatic finish_pkt(input string name);
    for (int i = 0; i < 400 && (obs_op.size() < exp_op.size() || obs_echo.size() < exp_echo.size()); i++)
      @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    check({name, "_err"}, 64'(err_seen), 64'(exp_err));
    if (exp_err != 0) check({name, "_err_after_byte"}, 64'(err_acc), 64'd4);
    check({name, "_n_ops"}, 64'(obs_op.size()), 64'(exp_op.size()));
    check({name, "_n_echo"}, 64'(obs_echo.size()), 64'(exp_echo.size()));
    foreach (exp_op[i])   if (i < obs_op.size())   check({name, "_op"}, 64'(obs_op[i]), 64'(exp_op[i]));
    foreach (exp_echo[i]) if (i < obs_echo.size()) check({name, "_echo"}, 64'(obs_echo[i]), 64'(exp_echo[i]));
  endtask

  task automatic run_packet(input string name);
    prep();
    send_pkt();
    finish_pkt(name);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", {s_axis_tready_o, m_opcode_o, m_operand_o, m_valid_o, m_last_o,
                            echo_tdata_o, echo_tvalid_o, echo_tlast_o, err_o}, 64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("tready_after_reset", 64'(s_axis_tready_o), 64'd1);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [7:0] op;
    int         kind;
    int         pay;

    repeat (2) @(posedge clk_i);
    #1;
    pulse_reset();

    pkt_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00};
    run_packet("add2");

    rdy_mode = 2;
    stall_cycles = 0;
    prep();
    fork
      send_pkt();
      begin
        for (int i = 0; i < 200 && !m_valid_o; i++) @(negedge clk_i);
        if (!m_valid_o) timeouts++;
        repeat (10) @(posedge clk_i);
        rdy_mode = 0;
      end
    join
    finish_pkt("backpressure");
    check("bp_stalled", 64'(stall_cycles >= 10), 64'd1);

    pkt_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_packet("echo4");

    pkt_q = '{8'h01, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    run_packet("bad_len");
    pkt_q = '{8'h01, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_packet("add_after_drain");

    pkt_q = '{8'h55, 8'h00, 8'h04, 8'h00};
    run_packet("unknown_op");
    pkt_q = '{8'h01, 8'h00, 8'h02, 8'h00};
    run_packet("short_len");

    // Maximum length echo: only the first bytes are sent, then the packet is abandoned by reset.
    pkt_q = '{8'hEC, 8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    obs_echo.delete();
    err_seen = 0;
    send_pkt();
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    check("maxlen_n_echo", 64'(obs_echo.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < obs_echo.size()) check("maxlen_echo", 64'(obs_echo[i]), 64'({1'b0, pkt_q[4 + i]}));
    check("maxlen_err", 64'(err_seen), 64'd0);
    pulse_reset();

    // Reset two bytes into the first operand.
    pkt_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56};
    obs_op.delete();
    send_pkt();
    pulse_reset();
    check("reset_mid_no_op", 64'(obs_op.size()), 64'd0);
    pkt_q = '{8'h02, 8'h00, 8'h08, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    run_packet("after_reset");

`ifdef UART_ALU_PARSER_TIMEOUT_EN
    pkt_q = '{8'h01, 8'h00, 8'h08, 8'h00};
    err_seen = 0;
    send_pkt();
    repeat (100) @(negedge clk_i);
    check("tmo_not_early", 64'(err_seen), 64'd0);
    repeat (3) @(negedge clk_i);
    check("tmo_err", 64'(err_seen), 64'd1);
    @(posedge clk_i);
    #1;
    pkt_q = '{8'h03, 8'h00, 8'h08, 8'h00, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    run_packet("after_timeout");
`endif

    gaps = 1'b1;
    for (int p = 0; p < 16; p++) begin
      rdy_mode  = int'($urandom_range(0, 1));
      echo_mode = int'($urandom_range(0, 1));
      kind      = int'($urandom_range(0, 4));
      case (kind)
        0: make_packet(8'($urandom_range(1, 15)), 4 + 4 * int'($urandom_range(1, 5)));
        1: make_packet(8'hEC, 4 + int'($urandom_range(0, 12)));
        2: begin
          pay = int'($urandom_range(0, 11));
          if (pay % 4 == 0 && pay != 0) pay++;
          make_packet(8'($urandom_range(1, 15)), 4 + pay);
        end
        3: begin
          op = 8'($urandom_range(16, 255));
          if (op == 8'hEC) op = 8'hED;
          make_packet(op, 4 + int'($urandom_range(0, 8)));
        end
        default: make_packet(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      endcase
      run_packet("rand");
    end

    check("hold_violations", 64'(hold_viol), 64'd0);
    check("tready_during_emit", 64'(emit_rdy_viol), 64'd0);
    check("err_pulse_width", 64'(err_long), 64'd0);
    check("bounded_waits", 64'(timeouts), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
